// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter sharing one TX pin: byte-granular round-robin
// arbitration plus an optional hold window that keeps a packet from one owner contiguous.
module uart_tx_arbiter #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned BAUD        = 1000000,
    parameter int unsigned HOLD_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in0_valid_i,
    input  logic [7:0] in0_data_i,
    output logic       in0_ready_o,
    input  logic       in1_valid_i,
    input  logic [7:0] in1_data_i,
    output logic       in1_ready_o,
    output logic       txd_o,
    output logic       busy_o,
    output logic       owner_o
);

    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned BW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int unsigned HW  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_STOP = BW'(DIV - 2);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_arbiter: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [HW-1:0] hold_cnt;
    logic          owner;
    logic          txd;
    logic          busy;
    logic          lock;
    logic          bit_end;
    logic          grant;
    logic          sel;

    assign lock    = (hold_cnt != '0);
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        grant      = 1'b0;
        sel        = owner;
        state_next = state;
        case (state)
            IDLE: begin
                if (!rst_i) begin
                    if (lock) begin
                        grant = owner ? in1_valid_i : in0_valid_i;
                    end else if (in0_valid_i && in1_valid_i) begin
                        grant = 1'b1;
                        sel   = ~owner;
                    end else if (in0_valid_i) begin
                        grant = 1'b1;
                        sel   = 1'b0;
                    end else if (in1_valid_i) begin
                        grant = 1'b1;
                        sel   = 1'b1;
                    end
                end
                if (grant) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_next = STOP;
                end
            end
            // STOP covers DIV-1 cycles; the final stop cycle is spent in IDLE so a
            // new byte can be accepted there and frames run back-to-back.
            STOP: begin
                if (baud_cnt == BAUD_STOP) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in0_ready_o = grant && !sel;
        in1_ready_o = grant && sel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txd      <= 1'b1;
            busy     <= 1'b0;
            owner    <= 1'b0;
            shift    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (grant) begin
                        shift <= sel ? in1_data_i : in0_data_i;
                        owner <= sel;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (lock) begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        shift    <= shift >> 1;
                        txd      <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_STOP) begin
                        baud_cnt <= '0;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    assign txd_o   = txd;
    assign busy_o  = busy;
    assign owner_o = owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a no-hold and a hold instance checked cycle by cycle
// against a frame-timing reference model, plus directed scenario checks.
module tb_uart_tx_arbiter;

    localparam int CLK_FREQ = 40;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
    localparam int HOLD1    = 16;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] v0;
    logic [1:0] v1;
    logic [1:0] r0;
    logic [1:0] r1;
    logic [1:0] txd;
    logic [1:0] busy;
    logic [1:0] owner;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HOLD_CYCLES(0)) u_nohold (
        .clk_i(clk), .rst_i(rst[0]),
        .in0_valid_i(v0[0]), .in0_data_i(d0[0]), .in0_ready_o(r0[0]),
        .in1_valid_i(v1[0]), .in1_data_i(d1[0]), .in1_ready_o(r1[0]),
        .txd_o(txd[0]), .busy_o(busy[0]), .owner_o(owner[0])
    );

    uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HOLD_CYCLES(HOLD1)) u_hold (
        .clk_i(clk), .rst_i(rst[1]),
        .in0_valid_i(v0[1]), .in0_data_i(d0[1]), .in0_ready_o(r0[1]),
        .in1_valid_i(v1[1]), .in1_data_i(d1[1]), .in1_ready_o(r1[1]),
        .txd_o(txd[1]), .busy_o(busy[1]), .owner_o(owner[1])
    );

    // Reference model: everything is derived from the cycle of the last accept.
    int         now = 0;
    int         acc [2] = '{-1, -1};
    int         hold [2] = '{0, 0};
    logic [7:0] cur [2];
    logic       own [2] = '{1'b0, 1'b0};
    logic [4:0] exp_vec [2];

    function automatic void model_eval(int k);
        int   n;
        int   b;
        logic t;
        logic act;
        logic idle;
        logic g;
        logic sel;
        if (rst[k]) begin
            acc[k]     = -1;
            own[k]     = 1'b0;
            hold[k]    = 0;
            exp_vec[k] = 5'b00100;
            return;
        end
        n    = now - acc[k];
        act  = (acc[k] >= 0) && (n >= 1) && (n <= FRAME);
        idle = (acc[k] < 0) || (n >= FRAME);
        t    = 1'b1;
        if (act) begin
            b = (n - 1) / DIV;
            if (b == 0) t = 1'b0;
            else if (b <= 8) t = cur[k][b-1];
        end
        if (acc[k] >= 0 && n == FRAME) hold[k] = (k == 0) ? 0 : HOLD1;
        g   = 1'b0;
        sel = own[k];
        if (idle) begin
            if (hold[k] > 0) begin
                g = own[k] ? v1[k] : v0[k];
            end else if (v0[k] && v1[k]) begin
                g   = 1'b1;
                sel = !own[k];
            end else if (v0[k]) begin
                g   = 1'b1;
                sel = 1'b0;
            end else if (v1[k]) begin
                g   = 1'b1;
                sel = 1'b1;
            end
        end
        exp_vec[k] = {g && !sel, g && sel, t, act, own[k]};
        if (g) begin
            acc[k] = now;
            cur[k] = sel ? d1[k] : d0[k];
            own[k] = sel;
        end else if (idle && hold[k] > 0) begin
            hold[k]--;
        end
    endfunction

    always @(negedge clk) begin
        now++;
        model_eval(0);
        model_eval(1);
    end

    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 2'b11;
        v0  = 2'b11;
        v1  = 2'b11;
        repeat (3) begin
            to_sample();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ({r0[k], r1[k], txd[k], busy[k], owner[k]} !== 5'b00100) begin
                    n_bad++;
                    $display("FAIL reset k=%0d {r0,r1,txd,busy,owner} got %b want 00100",
                             k, {r0[k], r1[k], txd[k], busy[k], owner[k]});
                end
            end
            to_drive();
        end
        v0  = '0;
        v1  = '0;
        rst = '0;
        repeat (2) begin
            to_sample();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ({r0[k], r1[k], txd[k], busy[k], owner[k]} !== 5'b00100) begin
                    n_bad++;
                    $display("FAIL reset_idle k=%0d got %b want 00100",
                             k, {r0[k], r1[k], txd[k], busy[k], owner[k]});
                end
            end
            to_drive();
        end
    endtask

    task automatic test_single();
        int s;
        int t       = -1;
        int nready  = 0;
        int b_end   = -1;
        v0[0] = 1'b1;
        d0[0] = 8'h55;
        for (int i = 0; i < FRAME + 6; i++) begin
            to_sample();
            if (i == 0) s = now;
            n_cmp++;
            if ({r0[0], r1[0], txd[0], busy[0], owner[0]} !== exp_vec[0]) begin
                n_bad++;
                $display("FAIL single cyc=%0d got %b want %b", now,
                         {r0[0], r1[0], txd[0], busy[0], owner[0]}, exp_vec[0]);
            end
            if (r0[0]) begin
                nready++;
                if (t < 0) t = now;
            end
            if (t >= 0 && now > t && !busy[0] && b_end < 0) b_end = now;
            to_drive();
            if (t >= 0) v0[0] = 1'b0;
        end
        n_cmp++;
        if (t !== s || nready !== 1) begin
            n_bad++;
            $display("FAIL single_ready accept=%0d pulses=%0d want accept=%0d pulses=1", t, nready, s);
        end
        n_cmp++;
        if (b_end !== s + FRAME + 1) begin
            n_bad++;
            $display("FAIL single_busy_fall got cyc %0d want %0d", b_end, s + FRAME + 1);
        end
    endtask

    task automatic test_contention();
        int s;
        int t0 = -1;
        int t1 = -1;
        rst[0] = 1'b1;
        v0[0]  = 1'b1;
        d0[0]  = 8'hA1;
        v1[0]  = 1'b1;
        d1[0]  = 8'h3C;
        to_sample();
        to_drive();
        rst[0] = 1'b0;
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            to_sample();
            if (i == 0) s = now;
            n_cmp++;
            if ({r0[0], r1[0], txd[0], busy[0], owner[0]} !== exp_vec[0]) begin
                n_bad++;
                $display("FAIL contention cyc=%0d got %b want %b", now,
                         {r0[0], r1[0], txd[0], busy[0], owner[0]}, exp_vec[0]);
            end
            if (r0[0] && t0 < 0) t0 = now;
            if (r1[0] && t1 < 0) t1 = now;
            to_drive();
            if (t0 >= 0) v0[0] = 1'b0;
            if (t1 >= 0) v1[0] = 1'b0;
        end
        n_cmp++;
        if (t1 !== s || t0 !== s + FRAME) begin
            n_bad++;
            $display("FAIL contention_order in1@%0d in0@%0d want in1@%0d in0@%0d", t1, t0, s, s + FRAME);
        end
    endtask

    task automatic test_hold_stream();
        int acc0 [3] = '{-1, -1, -1};
        int sent = 0;
        int t1   = -1;
        logic a;
        rst[1] = 1'b1;
        to_sample();
        to_drive();
        rst[1] = 1'b0;
        v0[1]  = 1'b1;
        d0[1]  = 8'($urandom);
        d1[1]  = 8'hC3;
        for (int i = 0; i < 4 * FRAME; i++) begin
            to_sample();
            n_cmp++;
            if ({r0[1], r1[1], txd[1], busy[1], owner[1]} !== exp_vec[1]) begin
                n_bad++;
                $display("FAIL hold_stream cyc=%0d got %b want %b", now,
                         {r0[1], r1[1], txd[1], busy[1], owner[1]}, exp_vec[1]);
            end
            a = r0[1] && v0[1];
            if (a && sent < 3) begin
                acc0[sent] = now;
                sent++;
            end
            if (r1[1] && t1 < 0) t1 = now;
            to_drive();
            v1[1] = (t1 < 0);
            if (a) begin
                if (sent < 3) d0[1] = 8'($urandom);
                else v0[1] = 1'b0;
            end
        end
        n_cmp++;
        if (sent !== 3 || t1 !== acc0[2] + FRAME + HOLD1) begin
            n_bad++;
            $display("FAIL hold_stream_order in0_sent=%0d in1@%0d want 3 and in1@%0d",
                     sent, t1, acc0[2] + FRAME + HOLD1);
        end
    endtask

    task automatic test_hold_idle();
        int t0 = -1;
        int t1 = -1;
        int n1 = 0;
        rst[1] = 1'b1;
        to_sample();
        to_drive();
        rst[1] = 1'b0;
        v0[1]  = 1'b1;
        d0[1]  = 8'h5A;
        d1[1]  = 8'h96;
        for (int i = 0; i < FRAME + HOLD1 + FRAME / 2; i++) begin
            to_sample();
            n_cmp++;
            if ({r0[1], r1[1], txd[1], busy[1], owner[1]} !== exp_vec[1]) begin
                n_bad++;
                $display("FAIL hold_idle cyc=%0d got %b want %b", now,
                         {r0[1], r1[1], txd[1], busy[1], owner[1]}, exp_vec[1]);
            end
            if (r0[1] && t0 < 0) t0 = now;
            if (r1[1]) begin
                n1++;
                if (t1 < 0) t1 = now;
            end
            to_drive();
            if (t0 >= 0) v0[1] = 1'b0;
            v1[1] = (t1 < 0);
        end
        n_cmp++;
        if (n1 !== 1 || t1 !== t0 + FRAME + HOLD1) begin
            n_bad++;
            $display("FAIL hold_idle_grant in1 pulses=%0d @%0d want 1 @%0d", n1, t1, t0 + FRAME + HOLD1);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        int t   = -1;
        int rel;
        int t2  = -1;
        v0[0] = 1'b1;
        d0[0] = 8'hFF;
        for (int i = 0; i <= 1 + 4 * DIV; i++) begin
            to_sample();
            if (i == 0) s = now;
            n_cmp++;
            if ({r0[0], r1[0], txd[0], busy[0], owner[0]} !== exp_vec[0]) begin
                n_bad++;
                $display("FAIL reset_mid_pre cyc=%0d got %b want %b", now,
                         {r0[0], r1[0], txd[0], busy[0], owner[0]}, exp_vec[0]);
            end
            if (r0[0] && t < 0) t = now;
            to_drive();
            if (t >= 0) v0[0] = 1'b0;
        end
        #1;
        n_cmp++;
        if (t !== s || busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_frame accept=%0d busy=%b want accept=%0d busy=1", t, busy[0], s);
        end
        rst[0] = 1'b1;
        v0[0]  = 1'b1;
        d0[0]  = 8'h00;
        #1;
        n_cmp++;
        if ({txd[0], busy[0], r0[0], owner[0]} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_async {txd,busy,r0,owner} got %b want 1000",
                     {txd[0], busy[0], r0[0], owner[0]});
        end
        to_drive();
        rst[0] = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            to_sample();
            if (i == 0) rel = now;
            n_cmp++;
            if ({r0[0], r1[0], txd[0], busy[0], owner[0]} !== exp_vec[0]) begin
                n_bad++;
                $display("FAIL reset_mid_post cyc=%0d got %b want %b", now,
                         {r0[0], r1[0], txd[0], busy[0], owner[0]}, exp_vec[0]);
            end
            if (r0[0] && t2 < 0) t2 = now;
            to_drive();
            if (t2 >= 0) v0[0] = 1'b0;
        end
        n_cmp++;
        if (t2 !== rel) begin
            n_bad++;
            $display("FAIL reset_mid_restart accept@%0d want @%0d", t2, rel);
        end
    endtask

    task automatic test_back_to_back();
        logic       line [6 * FRAME];
        logic [9:0] fr;
        int         s;
        int         first = -1;
        int         last  = -1;
        int         nacc  = 0;
        int         base;
        v1[0] = 1'b1;
        d1[0] = 8'h7E;
        for (int i = 0; i < 6 * FRAME; i++) begin
            to_sample();
            if (i == 0) s = now;
            line[i] = txd[0];
            n_cmp++;
            if ({r0[0], r1[0], txd[0], busy[0], owner[0]} !== exp_vec[0]) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got %b want %b", now,
                         {r0[0], r1[0], txd[0], busy[0], owner[0]}, exp_vec[0]);
            end
            if (r1[0]) begin
                nacc++;
                if (first < 0) begin
                    first = now;
                end else begin
                    n_cmp++;
                    if (now - last !== FRAME) begin
                        n_bad++;
                        $display("FAIL back_to_back_spacing got %0d want %0d", now - last, FRAME);
                    end
                end
                last = now;
            end
            to_drive();
            if (i == 5 * FRAME - 1) v1[0] = 1'b0;
        end
        n_cmp++;
        if (nacc !== 5 || first !== s) begin
            n_bad++;
            $display("FAIL back_to_back_count accepts=%0d first@%0d want 5 first@%0d", nacc, first, s);
        end
        for (int f = 0; f < 5; f++) begin
            base = (first - s) + f * FRAME + 1 + DIV / 2;
            for (int b = 0; b < 10; b++) fr[b] = line[base + b * DIV];
            n_cmp++;
            if (fr !== {1'b1, 8'h7E, 1'b0}) begin
                n_bad++;
                $display("FAIL back_to_back_decode frame=%0d got %b want %b", f, fr, {1'b1, 8'h7E, 1'b0});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] a0;
        logic [1:0] a1;
        for (int i = 0; i < 3000; i++) begin
            to_sample();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if ({r0[k], r1[k], txd[k], busy[k], owner[k]} !== exp_vec[k]) begin
                    n_bad++;
                    $display("FAIL random k=%0d cyc=%0d got %b want %b", k, now,
                             {r0[k], r1[k], txd[k], busy[k], owner[k]}, exp_vec[k]);
                end
                a0[k] = r0[k] && v0[k];
                a1[k] = r1[k] && v1[k];
            end
            to_drive();
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) rst[k] = 1'b0;
                else if ($urandom_range(0, 599) == 0) rst[k] = 1'b1;
                if (a0[k]) begin
                    v0[k] = 1'($urandom_range(0, 1));
                    d0[k] = 8'($urandom);
                end else if (!v0[k] && $urandom_range(0, 2) == 0) begin
                    v0[k] = 1'b1;
                    d0[k] = 8'($urandom);
                end
                if (a1[k]) begin
                    v1[k] = 1'($urandom_range(0, 1));
                    d1[k] = 8'($urandom);
                end else if (!v1[k] && $urandom_range(0, 2) == 0) begin
                    v1[k] = 1'b1;
                    d1[k] = 8'($urandom);
                end
            end
        end
        v0  = '0;
        v1  = '0;
        rst = '0;
    endtask

    initial begin
        rst   = 2'b00;
        v0    = 2'b00;
        v1    = 2'b00;
        d0[0] = 8'h00;
        d0[1] = 8'h00;
        d1[0] = 8'h00;
        d1[1] = 8'h00;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_hold_stream();
        test_hold_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single board UART TX pin between two byte-stream transmitters: the debug bridge (port 0) and the SoC UART (port 1).
- Replaces wire-ANDing two serial lines, which garbles output when both talk at once. Each requester hands over whole bytes. The block serialises them 8N1 and arbitrates at byte granularity.
- A hold window keeps a packet from one requester contiguous.
- Sits in the board top between the core's byte outputs and the IOB TX flop.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 1000000, line rate. DIV = CLK_FREQ/BAUD (integer division). DIV >= 2 is required; elaboration error otherwise.
- HOLD_CYCLES, 64, idle cycles after a stop bit during which only the last owner may be granted. 0 disables hold.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- in0_valid_i  input  1  requester 0 (debug) has a byte
- in0_data_i  input  8  requester 0 byte
- in0_ready_o  output  1  requester 0 byte accepted this cycle
- in1_valid_i  input  1  requester 1 (SoC UART) has a byte
- in1_data_i  input  8  requester 1 byte
- in1_ready_o  output  1  requester 1 byte accepted this cycle
- txd_o  output  1  serial output, idle high, registered
- busy_o  output  1  frame in progress
- owner_o  output  1  index of last granted requester

Behaviour:
- Reset values: txd_o=1, busy_o=0, owner_o=0, both ready=0, FSM=IDLE, lock=0, hold counter=0, bit/baud counters=0.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- Handshake: a byte transfers on a cycle with valid & ready.
  - ready is combinational and asserts only in IDLE, only for the selected requester.
  - Data is captured into the shift register on that cycle.
  - valid must stay asserted with stable data until accepted; the block never drops or duplicates a byte.
- Selection in IDLE:
  - If locked (hold counter > 0): only owner may be granted. The other requester waits even if valid.
  - If unlocked and both valid: grant the requester != owner_o (round robin).
  - If unlocked and one valid: grant that requester.
  - If neither valid: no grant.
  - owner_o updates to the granted index on the accept edge.
- Timing for an accept at cycle T:
  - txd_o=0 (start bit) from T+1 for DIV cycles.
  - Then 8 data bits, LSB first, DIV cycles each.
  - Then stop bit (1) for DIV cycles.
  - busy_o=1 from T+1 through T+10*DIV.
  - FSM re-enters IDLE at T+10*DIV; the next accept can happen that same cycle, giving back-to-back frames with no idle gap.
- Baud counter: counts 0..DIV-1 per bit and resets on each bit advance. The bit index counts 0..7 in DATA.
- Hold behaviour:
  - On the last stop cycle the hold counter loads HOLD_CYCLES and lock=1.
  - Each IDLE cycle without a grant decrements the counter; lock clears when it reaches 0.
  - A grant to the owner during hold starts a new frame. The counter reloads at that frame's stop bit.
  - With HOLD_CYCLES=0, lock never sets.
- Simultaneous events: the two requests rising in the same cycle while unlocked resolve by round robin. After reset owner_o=0, so requester 1 wins the first contention.
- Validity drop: deasserting valid before acceptance (protocol violation) has no effect on an in-progress frame.
- Reset mid-frame: txd_o returns to 1 immediately (asynchronous). The partial frame is abandoned and no ready is issued.

Test Plan:
- CLK_FREQ=40, BAUD=10 (DIV=4), HOLD_CYCLES=0; in0 sends 0x55 at cycle T -> in0_ready_o=1 at T only; txd_o is 0 for T+1..T+4, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then stop high for 4 cycles; busy_o falls after T+40.
- Both valid from reset, in0=0xA1, in1=0x3C, HOLD_CYCLES=0 -> in1 granted first (owner_o=1), in0 granted at T+40. Line carries 0x3C then 0xA1 with no gap.
- HOLD_CYCLES=16; in0 streams 3 bytes back-to-back while in1 is valid throughout -> all 3 in0 bytes sent before in1 is granted. in1 is granted 16 idle cycles after in0 drops valid.
- HOLD_CYCLES=16; in0 goes idle after one byte, in1 valid -> in1_ready_o stays 0 for 16 cycles after the stop bit, then pulses for one cycle.
- Assert rst_i during DATA bit 3 of 0xFF -> txd_o=1 and busy_o=0 asynchronously. After release, a new byte 0x00 is framed correctly from its start bit.
- in1 holds valid with data 0x7E and no contention -> exactly one accept per 40 cycles; 5 frames decode to 0x7E with no duplicates.
